// File: rtl/seg_disp_pkg.sv
// Shared constants for the multiplexed seven-segment scanner: glyph table,
// blank pattern and parameter legality limits.
package seg_disp_pkg;

    // Segment order is {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Entry n is the glyph for nibble value n (listed here from F down to 0).
    localparam logic [15:0][6:0] SEG_GLYPHS = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    localparam int NUM_DIGITS_MIN  = 1;
    localparam int NUM_DIGITS_MAX  = 8;
    localparam int REFRESH_DIV_MIN = 1;
    localparam int BLINK_DIV_MIN   = 1;

endpackage

// File: rtl/seg_decode.sv
// Nibble to seven-segment glyph decoder; in BCD mode values 10-15 are blank.
module seg_decode
    import seg_disp_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       hex_mode,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_GLYPHS[nibble];
        if (!hex_mode && (nibble > 4'd9)) begin
            seg = SEG_BLANK;
        end
    end

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment scanner with per-digit blink and decimal points.
// Optional leading-zero suppression is enabled by defining SEG_LEADING_ZERO_BLANK_EN.
module seg_scan_display
    import seg_disp_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic                    hex_mode,
    input  logic                    blink_en,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

    if ((NUM_DIGITS < NUM_DIGITS_MIN) || (NUM_DIGITS > NUM_DIGITS_MAX) ||
        (REFRESH_DIV < REFRESH_DIV_MIN) || (BLINK_DIV < BLINK_DIV_MIN)) begin : g_bad_param
        $error("seg_scan_display: illegal parameter value");
    end

    logic [REF_W-1:0]      refresh_q, refresh_d;
    logic [IDX_W-1:0]      index_q, index_d;
    logic [BLK_W-1:0]      blink_cnt_q, blink_cnt_d;
    logic                  phase_q, phase_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;

    logic [3:0] nibble;
    logic       blink_bit;
    logic       dp_bit;
    logic       blink_blank;
    logic       lz_blank;
    logic [6:0] glyph;

    // Scan walks from the leftmost digit downwards and wraps back to it.
    always_comb begin
        refresh_d = refresh_q + REF_W'(1);
        index_d   = index_q;
        if (refresh_q == REF_LAST) begin
            refresh_d = '0;
            index_d   = (index_q == '0) ? LAST_IDX : index_q - IDX_W'(1);
        end
    end

    always_comb begin
        blink_cnt_d = '0;
        phase_d     = 1'b0;
        if (blink_en) begin
            blink_cnt_d = blink_cnt_q + BLK_W'(1);
            phase_d     = phase_q;
            if (blink_cnt_q == BLK_LAST) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end
        end
    end

    always_comb begin
        nibble    = 4'h0;
        blink_bit = 1'b0;
        dp_bit    = 1'b0;
        an_d      = '1;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (IDX_W'(j) == index_q) begin
                nibble    = digits[4*j +: 4];
                blink_bit = blink_mask[j];
                dp_bit    = dp_mask[j];
                an_d[j]   = 1'b0;
            end
        end
    end

`ifdef SEG_LEADING_ZERO_BLANK_EN
    // Walking down from the top, upper_zero holds while every nibble seen so far is zero.
    always_comb begin
        logic upper_zero;
        upper_zero = 1'b1;
        lz_blank   = 1'b0;
        for (int j = NUM_DIGITS - 1; j >= 1; j--) begin
            if (digits[4*j +: 4] != 4'h0) begin
                upper_zero = 1'b0;
            end
            if (IDX_W'(j) == index_q) begin
                lz_blank = upper_zero;
            end
        end
    end
`else
    assign lz_blank = 1'b0;
`endif

    seg_decode u_seg_decode (
        .nibble   (nibble),
        .hex_mode (hex_mode),
        .seg      (glyph)
    );

    // Blink blanking kills the decimal point too; leading-zero blanking does not.
    always_comb begin
        blink_blank = blink_en && blink_bit && phase_q;
        seg_d       = (blink_blank || lz_blank) ? SEG_BLANK : glyph;
        dp_d        = ~(dp_bit && !blink_blank);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_q   <= '0;
            index_q     <= LAST_IDX;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            seg_q       <= SEG_BLANK;
            dp_q        <= 1'b1;
            an_q        <= '1;
        end else begin
            refresh_q   <= refresh_d;
            index_q     <= index_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            an_q        <= an_d;
        end
    end

    assign seg = seg_q;
    assign dp  = dp_q;
    assign an  = an_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Self-checking bench for seg_scan_display (4 digits, refresh 4, blink 16).
module tb_seg_scan_display;

    localparam int ND = 4;
    localparam int RD = 4;
    localparam int BD = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [4*ND-1:0] digits;
    logic            hex_mode;
    logic            blink_en;
    logic [ND-1:0]   blink_mask;
    logic [ND-1:0]   dp_mask;
    logic [6:0]      seg;
    logic            dp;
    logic [ND-1:0]   an;

    seg_scan_display #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .BLINK_DIV   (BD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .digits     (digits),
        .hex_mode   (hex_mode),
        .blink_en   (blink_en),
        .blink_mask (blink_mask),
        .dp_mask    (dp_mask),
        .seg        (seg),
        .dp         (dp),
        .an         (an)
    );

    // ---------------- scoreboard ----------------
    logic [11:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int k = 0;   // edges since reset release
    int b = 0;   // consecutive edges with blink_en high

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] tb_glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    // Expected {an, seg, dp} for the next edge, from elapsed-time arithmetic.
    function automatic logic [11:0] model_out();
        int         idx;
        logic [3:0] nib;
        logic [6:0] s;
        logic       bb;
        logic       lz;
        logic [3:0] an_e;
        logic       dp_e;
        idx = ND - 1 - ((k / RD) % ND);
        nib = digits[4*idx +: 4];
        s   = tb_glyph(nib);
        if (!hex_mode && nib > 4'd9) s = 7'b1111111;
        bb  = blink_en && blink_mask[idx] && (((b / BD) % 2) == 1);
        lz  = 1'b0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        if (idx != 0 && (digits >> (4*idx)) == '0) lz = 1'b1;
`endif
        if (bb || lz) s = 7'b1111111;
        an_e      = 4'hF;
        an_e[idx] = 1'b0;
        dp_e      = ~(dp_mask[idx] && !bb);
        return {an_e, s, dp_e};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
        b = blink_en ? b + 1 : 0;
        k++;
        check_eq("scan", {an, seg, dp}, exp_q.pop_front());
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_an"}, an, 4'b1111);
        check_eq({tag, "_seg"}, seg, 7'b1111111);
        check_eq({tag, "_dp"}, dp, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        digits     = 16'h1259;
        hex_mode   = 1'b0;
        blink_en   = 1'b0;
        blink_mask = '0;
        dp_mask    = '0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");

        rst = 1'b0;
        k = 0;
        b = 0;
        step();
        check_eq("first_an", an, 4'b0111);
        check_eq("first_seg", seg, 7'b1111001);
        run(39);

        digits = 16'h00AF;
        run(16);
        hex_mode = 1'b1;
        dp_mask  = 4'b0010;
        run(16);

        digits     = 16'h1259;
        hex_mode   = 1'b0;
        dp_mask    = 4'b0011;
        blink_en   = 1'b1;
        blink_mask = 4'b0011;
        run(24);
        blink_en = 1'b0;
        run(4);
        blink_en = 1'b1;
        run(40);
        blink_en = 1'b0;

        digits  = 16'h0007;
        dp_mask = '0;
        run(16);
        digits = 16'h0000;
        run(16);

        for (int i = 0; i < 150; i++) begin
            digits     = 16'($urandom);
            hex_mode   = 1'($urandom_range(0, 1));
            dp_mask    = 4'($urandom_range(0, 15));
            blink_mask = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) blink_en = ~blink_en;
            step();
        end

        // Asynchronous reset between edges, mid-hold.
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        @(posedge clk);
        #1;
        check_reset_outputs("async_hold");
        rst = 1'b0;
        k = 0;
        b = 0;
        step();
        check_eq("restart_an", an, 4'b0111);
        run(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
